// File: rtl/multi_ch_prescaler.sv
// rtl/multi_ch_prescaler.sv - multi-channel programmable clock prescaler with tick and square outputs
//
// Each channel divides sysclk by a runtime-programmable divisor D, giving a
// one-cycle tick every D cycles and a 50% square output of period 2*D.
// New divisors are staged in a pending register and only take effect at a
// terminal count or a sync pulse, so no output period is ever truncated.
//
// Ports:
//   sysclk     - system clock, rising edge
//   i_rst      - synchronous active-high reset
//   i_en       - per-channel run enable (counter and o_clk hold when low)
//   i_sync     - single-cycle pulse restarting every channel in phase
//   i_div_wr   - divisor write strobe
//   i_div_ch   - channel addressed by the write
//   i_div_val  - new divisor (must be >= 2)
//   o_tick     - one-cycle strobe per terminal count, per channel
//   o_clk      - square output toggling at each terminal count, per channel
//   o_div_err  - one-cycle pulse after a rejected write
module multi_ch_prescaler #(
    parameter int N_CH        = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 60,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             sysclk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_en,
    input  logic             i_sync,
    input  logic             i_div_wr,
    input  logic [CH_W-1:0]  i_div_ch,
    input  logic [DIV_W-1:0] i_div_val,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_clk,
    output logic             o_div_err
);

    logic [DIV_W-1:0] cnt      [N_CH];
    logic [DIV_W-1:0] div      [N_CH];
    logic [DIV_W-1:0] pend_div [N_CH];
    logic [N_CH-1:0]  pend_vld;
    logic [N_CH-1:0]  tick_q;
    logic [N_CH-1:0]  clk_q;
    logic             err_q;
    logic             wr_ok;

    // A write is accepted only for a divisor of at least 2 aimed at an
    // existing channel; anything else is dropped and flagged.
    assign wr_ok = i_div_wr && (i_div_val >= DIV_W'(2)) && (32'(i_div_ch) < N_CH);

    always_ff @(posedge sysclk) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt[c]      <= '0;
                div[c]      <= DIV_W'(DEFAULT_DIV);
                pend_div[c] <= DIV_W'(DEFAULT_DIV);
            end
            pend_vld <= '0;
            tick_q   <= '0;
            clk_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= i_div_wr && !wr_ok;
            for (int c = 0; c < N_CH; c++) begin
                if (i_sync) begin
                    // Restart in phase; a same-cycle write beats any staged value.
                    cnt[c]      <= '0;
                    clk_q[c]    <= 1'b0;
                    tick_q[c]   <= 1'b0;
                    pend_vld[c] <= 1'b0;
                    if (wr_ok && i_div_ch == CH_W'(c))
                        div[c] <= i_div_val;
                    else if (pend_vld[c])
                        div[c] <= pend_div[c];
                end else begin
                    tick_q[c] <= 1'b0;
                    if (i_en[c]) begin
                        if (cnt[c] == div[c] - DIV_W'(1)) begin
                            cnt[c]    <= '0;
                            tick_q[c] <= 1'b1;
                            clk_q[c]  <= ~clk_q[c];
                            if (pend_vld[c]) begin
                                div[c]      <= pend_div[c];
                                pend_vld[c] <= 1'b0;
                            end
                        end else begin
                            cnt[c] <= cnt[c] + DIV_W'(1);
                        end
                    end
                    // Placed after the wrap so a write landing on the terminal
                    // count stays pending for the following wrap.
                    if (wr_ok && i_div_ch == CH_W'(c)) begin
                        pend_div[c] <= i_div_val;
                        pend_vld[c] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_tick    = tick_q;
    assign o_clk     = clk_q;
    assign o_div_err = err_q;

endmodule

// File: tb/tb_multi_ch_prescaler.sv
// tb/tb_multi_ch_prescaler.sv - self-checking bench for multi_ch_prescaler
module tb_multi_ch_prescaler;

    localparam int N    = 3;
    localparam int DW   = 16;
    localparam int DEFD = 60;

    logic          sysclk = 1'b0;
    logic          i_rst;
    logic [N-1:0]  i_en;
    logic          i_sync;
    logic          i_div_wr;
    logic [1:0]    i_div_ch;
    logic [DW-1:0] i_div_val;
    logic [N-1:0]  o_tick;
    logic [N-1:0]  o_clk;
    logic          o_div_err;

    multi_ch_prescaler #(.N_CH(N), .DIV_W(DW), .DEFAULT_DIV(DEFD)) dut (
        .sysclk    (sysclk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_sync    (i_sync),
        .i_div_wr  (i_div_wr),
        .i_div_ch  (i_div_ch),
        .i_div_val (i_div_val),
        .o_tick    (o_tick),
        .o_clk     (o_clk),
        .o_div_err (o_div_err)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel has an elapsed-cycle count within its period,
    // the period length, and an optional staged period (0 = none staged).
    int m_elapsed [N];
    int m_period  [N];
    int m_staged  [N];
    bit m_level   [N];
    bit m_tick    [N];
    bit m_err;
    bit model_ok = 1'b0;

    always @(posedge sysclk) begin
        bit good;
        good = i_div_wr && (i_div_val >= 2) && (int'(i_div_ch) < N);
        if (i_rst) begin
            for (int c = 0; c < N; c++) begin
                m_elapsed[c] = 0; m_period[c] = DEFD; m_staged[c] = 0;
                m_level[c] = 0; m_tick[c] = 0;
            end
            m_err = 0;
            model_ok = 1'b1;
        end else begin
            m_err = i_div_wr && !good;
            for (int c = 0; c < N; c++) begin
                if (i_sync) begin
                    m_elapsed[c] = 0; m_level[c] = 0; m_tick[c] = 0;
                    if (good && int'(i_div_ch) == c) m_period[c] = int'(i_div_val);
                    else if (m_staged[c] != 0) m_period[c] = m_staged[c];
                    m_staged[c] = 0;
                end else begin
                    m_tick[c] = 0;
                    if (i_en[c]) begin
                        m_elapsed[c]++;
                        if (m_elapsed[c] == m_period[c]) begin
                            m_elapsed[c] = 0;
                            m_tick[c]    = 1;
                            m_level[c]   = !m_level[c];
                            if (m_staged[c] != 0) begin
                                m_period[c] = m_staged[c];
                                m_staged[c] = 0;
                            end
                        end
                    end
                    if (good && int'(i_div_ch) == c) m_staged[c] = int'(i_div_val);
                end
            end
        end
    end

    always @(negedge sysclk) begin
        logic [N-1:0] et, ec;
        if (model_ok) begin
            for (int c = 0; c < N; c++) begin
                et[c] = m_tick[c];
                ec[c] = m_level[c];
            end
            check("model_tick", 32'(o_tick), 32'(et));
            check("model_clk",  32'(o_clk),  32'(ec));
            check("model_err",  32'(o_div_err), 32'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        i_rst = 1'b1; i_en = '0; i_sync = 1'b0;
        i_div_wr = 1'b0; i_div_ch = '0; i_div_val = '0;
        step(2);
        check("reset_tick", 32'(o_tick), 32'd0);
        check("reset_clk",  32'(o_clk),  32'd0);
        check("reset_err",  32'(o_div_err), 32'd0);

        // Release reset with all channels enabled: first tick after edge 60.
        i_rst = 1'b0; i_en = '1;
        step(59);
        check("no_tick_edge59", 32'(o_tick), 32'd0);
        step(1);
        check("tick_edge60", 32'(o_tick), 32'b111);
        check("clk_edge60",  32'(o_clk),  32'b111);

        // Mid-period write to ch1 at count 25: current period completes.
        step(25);
        i_div_wr = 1'b1; i_div_ch = 2'd1; i_div_val = 16'd10;
        step(1);
        i_div_wr = 1'b0;
        step(33);
        check("no_tick_edge119", 32'(o_tick), 32'd0);
        step(1);
        check("tick_edge120", 32'(o_tick), 32'b111);
        step(10);
        check("ch1_tick_edge130", 32'(o_tick), 32'b010);

        // Rejected writes: D=1, D=0, channel index out of range.
        for (int k = 0; k < 3; k++) begin
            i_div_wr  = 1'b1;
            i_div_ch  = (k == 2) ? 2'd3 : 2'd0;
            i_div_val = (k == 0) ? 16'd1 : ((k == 1) ? 16'd0 : 16'd15);
            step(1);
            i_div_wr = 1'b0;
            check("err_pulse", 32'(o_div_err), 32'd1);
            step(1);
            check("err_clear", 32'(o_div_err), 32'd0);
        end

        // Sync with a same-cycle write to ch1 D=20.
        step(7);
        i_sync = 1'b1; i_div_wr = 1'b1; i_div_ch = 2'd1; i_div_val = 16'd20;
        step(1);
        i_sync = 1'b0; i_div_wr = 1'b0;
        check("sync_clk",  32'(o_clk),  32'd0);
        check("sync_tick", 32'(o_tick), 32'd0);
        step(19);
        check("sync_no_tick19", 32'(o_tick), 32'd0);
        step(1);
        check("sync_ch1_tick20", 32'(o_tick), 32'b010);
        step(40);
        check("sync_all_tick60", 32'(o_tick), 32'b111);

        // Reset with a pending write discards it; period back to 60.
        i_div_wr = 1'b1; i_div_ch = 2'd0; i_div_val = 16'd5;
        step(1);
        i_div_wr = 1'b0; i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        check("rst_mid_tick", 32'(o_tick), 32'd0);
        check("rst_mid_clk",  32'(o_clk),  32'd0);
        step(60);
        check("rst_period60", 32'(o_tick), 32'b111);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < N; c++) i_en[c] = ($urandom_range(0, 7) != 0);
            i_div_wr  = ($urandom_range(0, 19) == 0);
            i_div_ch  = 2'($urandom_range(0, 3));
            i_div_val = 16'($urandom_range(0, 25));
            i_sync    = ($urandom_range(0, 199) == 0);
            i_rst     = ($urandom_range(0, 999) == 0);
            step(1);
        end
        i_rst = 1'b0; i_sync = 1'b0; i_div_wr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_ch_prescaler.md
Name: multi_ch_prescaler

Overview:
- Parametrised, multi-channel successor to the fixed 60-count clock prescaler.
- Each channel divides sysclk by a runtime-programmable divisor D and produces two outputs:
  - a one-cycle tick strobe, period D;
  - a 50% square enable/clock, period 2*D.
- Divisor changes are glitch-free: they take effect only at a terminal count, or at a sync pulse.
- Feeds the PWM generator and the wash-cycle timers.
- A sync input phase-aligns all channels.

Parameters:
- N_CH, 2, number of independent divider channels (1..8).
- DIV_W, 16, width of divisor and counter.
- DEFAULT_DIV, 60, divisor loaded into every channel at reset (must be >= 2).

Ports:
- sysclk  input  1  system clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  N_CH  per-channel run enable.
- i_sync  input  1  single-cycle pulse; restarts all channels in phase.
- i_div_wr  input  1  divisor write strobe.
- i_div_ch  input  clog2(N_CH) (min 1)  channel index for the write.
- i_div_val  input  DIV_W  new divisor value.
- o_tick  output  N_CH  one-cycle strobe per terminal count.
- o_clk  output  N_CH  square output; toggles at each terminal count.
- o_div_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:

Reset (i_rst=1 at the edge):
- all counters=0, o_tick=0, o_clk=0, o_div_err=0.
- active div[ch]=DEFAULT_DIV, pend_div[ch]=DEFAULT_DIV, pend_vld[ch]=0.
- Reset dominates every other input.

Per channel ch, each edge with i_rst=0 and i_sync=0:
- i_en[ch]=0:
  - counter held (not cleared), o_clk held, o_tick=0.
  - A pending divisor still waits for the next wrap.
- i_en[ch]=1 and counter != div-1:
  - counter+=1, o_tick=0.
- i_en[ch]=1 and counter == div-1 (terminal):
  - counter<=0, o_tick<=1 for exactly one cycle, o_clk<=~o_clk.
  - If pend_vld: div<=pend_div, pend_vld<=0. The new D governs the very next period.

Latency and timing:
- All outputs are registered.
- With i_en held high from reset release, first o_tick is high after edge D. Tick period is exactly D cycles.
- o_clk high time = low time = D cycles.

Divisor write (i_div_wr=1):
- i_div_val >= 2 and i_div_ch < N_CH:
  - pend_div[i_div_ch]<=i_div_val, pend_vld<=1.
  - A second write before the wrap overwrites the first; last write wins.
- i_div_val < 2 or i_div_ch >= N_CH:
  - write ignored, o_div_err=1 for one cycle (registered, next cycle).
- A write in the same cycle as that channel's terminal count goes to pending. It is applied at the following wrap, not the current one.

Sync (i_sync=1, i_rst=0):
- every channel: counter<=0, o_clk<=0, o_tick<=0.
- Any pend_vld divisor is applied immediately.
- A divisor write in the same cycle as i_sync is applied immediately, bypassing pending.
- Sync acts regardless of i_en.

Arithmetic:
- counter compare uses the full DIV_W bits; the counter never exceeds div-1.
- Divisor values up to 2^DIV_W-1 are legal.

Test Plan:
- Reset, i_en=all 1, no writes -> first o_tick[0] after edge 60; ticks every 60 cycles; o_clk[0] toggles with period 120; both channels identical.
- Write ch1 D=10 while mid-count at counter=25 -> ch1 finishes the current 60-cycle period, then ticks every 10; ch0 unaffected.
- Write D=1, then D=0, then ch index=N_CH (N_CH=3 build) -> o_div_err pulses once per write; divisors unchanged, tick period stays 60.
- Drop i_en[0] for 7 cycles at counter=30 -> no ticks; counter resumes at 30; next tick 7 cycles later than nominal; o_clk level frozen during the gap.
- i_sync with ch0 counter=17, ch1 counter=44, plus a write to ch1 D=20 in the same cycle -> both counters 0, o_clk=0; ch0 ticks 60 cycles later, ch1 ticks 20 cycles later.
- Assert i_rst mid-period with a pending write -> all outputs 0, pending discarded, period back to 60.
